pipelined_shift_rotate: RTL and testbench
=========================================

Name: pipelined_shift_rotate

Overview:
- Parametrised, pipelined successor to the team's 16-bit combinational rotator.
- Supports rotate right/left, logical shift right/left, arithmetic shift right and pass-through on a WIDTH-bit word.
- One log-shifter stage per pipeline register, with a valid/ready handshake on both sides.
- Sits between operand source and writeback in the datapath; also usable standalone as a streaming shifter.

Parameters:
- WIDTH, 16, data width; power of two, >= 4.
- AMT_W, $clog2(WIDTH), localparam; shift-amount width and pipeline depth LAT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift/rotate amount, 0..WIDTH-1.
- in_op  in  3  operation code (see Behaviour).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  result.
- out_zero  out  1  1 when out_data == 0.

Behaviour:
- Reset: every stage valid bit cleared; out_valid=0, out_data=0, out_zero=1. in_ready=1 once reset deasserts.
- Reset asserted mid-operation discards all in-flight words. No result is produced for them.
- Op codes:
  - 000 ROR, 001 ROL, 010 SRL (zero fill), 011 SLL (zero fill), 100 SRA (sign-bit fill).
  - 101-111 pass-through: out_data = in_data, amount ignored.
- Left ops are implemented as right ops on the bit-reversed operand, with the result reversed back.
  - Reversal is combinational at the input and output; it adds no latency.
- Stage k (k = 0..AMT_W-1):
  - shifts right by 2^k when amt[k]=1, using the fill selected by op;
  - registers data, remaining amt bits, op and valid.
  - Stage AMT_W-1 is the output register.
- Latency: a word accepted in cycle t appears with out_valid=1 in cycle t+AMT_W if no stall occurs (4 cycles for WIDTH=16). Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - stall = out_valid && !out_ready. While stall=1 every stage holds its contents.
  - in_ready = !stall.
  - Bubbles (stage valid=0) still advance only when not stalled. No bubble collapsing.
- Stability: out_data, out_zero and out_valid stay stable while out_valid=1 and out_ready=0.
- Word integrity: no word is dropped or duplicated. Output order equals input order.
- Simultaneous in and out transfer in the same cycle is legal; the pipeline advances one step.
- amt=0 returns the operand unchanged for every op.
- SRA with amt=WIDTH-1 gives all sign bits.
- out_zero is registered with out_data, computed from the final-stage data.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [2:0] op_e {OP_ROR, OP_ROL, OP_SRL, OP_SLL, OP_SRA, OP_PASS}.
  - Helper function bit_reverse.
  - Helper function is_left(op_e).
- Sub-module shift_stage, parametrised by WIDTH and STAGE. It contains:
  - the conditional 2^STAGE right shift/rotate with fill;
  - the stage pipeline register with hold enable and asynchronous reset.
- The top instantiates AMT_W of these in a generate loop, plus the input/output reversal and handshake logic.

Test Plan (WIDTH=16):
- ROR 0x1234 amt=4, out_ready=1 -> out_data=0x4123 exactly 4 cycles after acceptance; out_zero=0.
- ROL 0x8001 amt=1 -> 0x0003. SLL 0x00FF amt=8 -> 0xFF00. PASS op=111 0xBEEF amt=5 -> 0xBEEF.
- SRA 0x8000 amt=15 -> 0xFFFF. SRL 0x8000 amt=15 -> 0x0001. SRL 0x0001 amt=1 -> 0x0000 with out_zero=1.
- Streaming with stall:
  - Stimulus: 8 back-to-back words; hold out_ready=0 for cycles 5-9.
  - Required: in_ready=0 during the stall; out_data held stable; all 8 results emerge in order with none lost or duplicated.
- Reset mid-flight:
  - Stimulus: 3 words accepted, then reset pulsed for 1 cycle before any output.
  - Required: out_valid=0 immediately (asynchronous); none of the 3 words ever appears at the output; the next accepted word completes normally in 4 cycles.
- Random sweep: 2000 random op/amt/data with random out_ready, compared against a reference model -> zero mismatches.

Source files
------------

// File: rtl/pipelined_shift_rotate_pkg.sv
// Shared types and helpers for the pipelined shifter/rotator.
// Left operations reuse the right-shift datapath on a bit-reversed word.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_ROR  = 3'd0,
    OP_ROL  = 3'd1,
    OP_SRL  = 3'd2,
    OP_SLL  = 3'd3,
    OP_SRA  = 3'd4,
    OP_PASS = 3'd5
  } op_e;

  // Upper bound on WIDTH that bit_reverse can handle.
  localparam int MAX_W = 256;

  // Reverses the low w bits of x; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

  function automatic logic is_left(input op_e op);
    return (op == OP_ROL) || (op == OP_SLL);
  endfunction

  // Codes 101..111 all collapse onto pass-through.
  function automatic op_e decode_op(input logic [2:0] raw);
    return (raw >= 3'd5) ? OP_PASS : op_e'(raw);
  endfunction

endpackage

// File: rtl/pipelined_shift_rotate_if.sv
// Streaming bus for the pipelined shifter: operand side in_*, result side out_*.
// A word moves on an edge where valid && ready; the sender holds valid and payload steady until it moves.
interface pipelined_shift_rotate_if #(parameter int WIDTH = 16);
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_shift_rotate_stage.sv
// One log-shifter stage: conditional right shift/rotate by 2**STAGE, then a
// pipeline register that holds its contents whenever en is low.
module shift_stage
  import shift_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  STAGE = 0,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  op_e              in_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt,
  output op_e              out_op,
  output logic             out_zero
);
  localparam int SH = 2 ** STAGE;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fill_mask;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [AMT_W-1:0] amt_d, amt_q;
  op_e              op_d, op_q;
  logic             zero_d, zero_q;

  always_comb begin
    fill_mask = ~({WIDTH{1'b1}} >> SH);
    shifted   = in_data;
    if (in_amt[STAGE]) begin
      case (in_op)
        OP_ROR, OP_ROL: shifted = (in_data >> SH) | (in_data << (WIDTH - SH));
        OP_SRL, OP_SLL: shifted = in_data >> SH;
        OP_SRA:         shifted = (in_data >> SH) | (in_data[WIDTH-1] ? fill_mask : '0);
        default:        shifted = in_data;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    zero_d  = zero_q;
    if (en) begin
      valid_d = in_valid;
      data_d  = shifted;
      amt_d   = in_amt;
      op_d    = in_op;
      zero_d  = (shifted == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= OP_PASS;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_op    = op_q;
  assign out_zero  = zero_q;

endmodule

// File: rtl/pipelined_shift_rotate.sv
// Pipelined WIDTH-bit shifter/rotator: AMT_W shift stages, one register each,
// with input/output bit reversal so left operations reuse the right-shift stages.
module pipelined_shift_rotate
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     reset,
  pipelined_shift_rotate_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);

  logic             stall;
  logic             advance;
  op_e              in_op_n;
  logic [AMT_W-1:0] in_amt_n;
  logic [WIDTH-1:0] in_word;
  logic [WIDTH-1:0] last_data;
  op_e              last_op;

  logic             stg_valid [AMT_W];
  logic [WIDTH-1:0] stg_data  [AMT_W];
  logic [AMT_W-1:0] stg_amt   [AMT_W];
  op_e              stg_op    [AMT_W];
  logic             stg_zero  [AMT_W];

  // The whole pipe freezes only when the output register cannot drain.
  assign stall   = stg_valid[AMT_W-1] & ~bus.out_ready;
  assign advance = ~stall;

  always_comb begin
    in_op_n  = decode_op(bus.in_op);
    in_amt_n = (in_op_n == OP_PASS) ? '0 : bus.in_amt;
    in_word  = bus.in_data;
    if (is_left(in_op_n)) in_word = WIDTH'(bit_reverse(MAX_W'(bus.in_data), WIDTH));
  end

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    logic             v_i;
    logic [WIDTH-1:0] d_i;
    logic [AMT_W-1:0] a_i;
    op_e              o_i;

    if (k == 0) begin : g_first
      assign v_i = bus.in_valid;
      assign d_i = in_word;
      assign a_i = in_amt_n;
      assign o_i = in_op_n;
    end else begin : g_next
      assign v_i = stg_valid[k-1];
      assign d_i = stg_data[k-1];
      assign a_i = stg_amt[k-1];
      assign o_i = stg_op[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .STAGE (k)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .in_valid  (v_i),
      .in_data   (d_i),
      .in_amt    (a_i),
      .in_op     (o_i),
      .out_valid (stg_valid[k]),
      .out_data  (stg_data[k]),
      .out_amt   (stg_amt[k]),
      .out_op    (stg_op[k]),
      .out_zero  (stg_zero[k])
    );
  end

  assign last_data = stg_data[AMT_W-1];
  assign last_op   = stg_op[AMT_W-1];

  always_comb begin
    bus.out_data = last_data;
    if (is_left(last_op)) bus.out_data = WIDTH'(bit_reverse(MAX_W'(last_data), WIDTH));
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = stg_valid[AMT_W-1];
  assign bus.out_zero  = stg_zero[AMT_W-1];

endmodule

// File: tb/tb_pipelined_shift_rotate.sv
// Bench for pipelined_shift_rotate (WIDTH=16): directed cases, stalled streaming,
// mid-flight reset and a randomized sweep against an arithmetic reference model.
module tb_pipelined_shift_rotate;
  localparam int W = 16;

  logic clk;
  logic reset;

  pipelined_shift_rotate_if #(.WIDTH(W)) bus_if ();

  pipelined_shift_rotate #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks      = 0;
  int failures    = 0;
  int n_out       = 0;
  int stall_count = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input int amt, input logic [W-1:0] d);
    logic [31:0] dd;
    dd = {16'h0000, d};
    case (op)
      3'd0:    return 16'((dd >> amt) | (dd << (W - amt)));
      3'd1:    return 16'((dd << amt) | (dd >> (W - amt)));
      3'd2:    return d >> amt;
      3'd3:    return 16'(dd << amt);
      3'd4:    return 16'($signed(d) >>> amt);
      default: return d;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // ---------------- driver tasks ----------------
  // Enters and leaves at posedge+1; returns right after the accepting edge.
  task automatic drive_word(input logic [2:0] op, input logic [3:0] amt, input logic [W-1:0] data);
    int waited;
    bus_if.in_valid = 1'b1;
    bus_if.in_op    = op;
    bus_if.in_amt   = amt;
    bus_if.in_data  = data;
    waited = 0;
    @(negedge clk);
    while (!bus_if.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) bound_fail("in_ready_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic run_directed(input string tag, input logic [2:0] op, input logic [3:0] amt,
                              input logic [W-1:0] data, input logic [W-1:0] exp_data, input logic exp_zero);
    int lat;
    drive_word(op, amt, data);
    bus_if.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus_if.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_data"}, bus_if.out_data, exp_data);
    check({tag, "_zero"}, bus_if.out_zero, exp_zero);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int cnt;
    bus_if.out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (exp_q.size() != 0) bound_fail(tag);
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_zero;
    logic [W-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_zero  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_hold", bus_if.out_valid, 1'b1);
          check("stall_data_hold", bus_if.out_data, prev_data);
          check("stall_zero_hold", bus_if.out_zero, prev_zero);
        end
        if (bus_if.out_valid && !bus_if.out_ready) begin
          stall_count++;
          check("in_ready_low_in_stall", bus_if.in_ready, 1'b0);
        end
        if (bus_if.out_valid && bus_if.out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            bound_fail("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            check("sb_data", bus_if.out_data, e);
            check("sb_zero", bus_if.out_zero, (e == '0));
          end
        end
        if (bus_if.in_valid && bus_if.in_ready)
          exp_q.push_back(ref_model(bus_if.in_op, int'(bus_if.in_amt), bus_if.in_data));
        prev_stall = bus_if.out_valid && !bus_if.out_ready;
        prev_data  = bus_if.out_data;
        prev_zero  = bus_if.out_zero;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int  out_before;
    int  stall_before;
    bit  done;

    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_op     = 3'd0;
    bus_if.in_amt    = '0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus_if.out_valid, 1'b0);
    check("reset_out_data", bus_if.out_data, 16'h0000);
    check("reset_out_zero", bus_if.out_zero, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", bus_if.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed operations with fixed expected results.
    run_directed("ror", 3'b000, 4'd4,  16'h1234, 16'h4123, 1'b0);
    run_directed("rol", 3'b001, 4'd1,  16'h8001, 16'h0003, 1'b0);
    run_directed("sll", 3'b011, 4'd8,  16'h00FF, 16'hFF00, 1'b0);
    run_directed("pass", 3'b111, 4'd5, 16'hBEEF, 16'hBEEF, 1'b0);
    run_directed("sra15", 3'b100, 4'd15, 16'h8000, 16'hFFFF, 1'b0);
    run_directed("srl15", 3'b010, 4'd15, 16'h8000, 16'h0001, 1'b0);
    run_directed("srl_zero", 3'b010, 4'd1, 16'h0001, 16'h0000, 1'b1);
    run_directed("amt0_ror", 3'b000, 4'd0, 16'hA5C3, 16'hA5C3, 1'b0);
    run_directed("amt0_sra", 3'b100, 4'd0, 16'h9F01, 16'h9F01, 1'b0);
    run_directed("rol15", 3'b001, 4'd15, 16'h0001, 16'h8000, 1'b0);

    // Streaming: 8 back-to-back words with out_ready low for cycles 5..9.
    out_before   = n_out;
    stall_before = stall_count;
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive_word(3'(i), 4'((i * 3) % 16), 16'($urandom_range(0, 16'hFFFF)));
        bus_if.in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus_if.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus_if.out_ready = 1'b1;
      end
    join
    drain("stream_drain");
    repeat (2) @(posedge clk);
    #1;
    check("stream_out_count", n_out - out_before, 8);
    check("stream_stall_cycles", stall_count - stall_before, 5);

    // Reset mid-flight: three words in the pipe, none may ever emerge.
    out_before = n_out;
    for (int i = 0; i < 3; i++) drive_word(3'd2, 4'd1, 16'h0F0F + 16'(i));
    bus_if.in_valid = 1'b0;
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_out_valid", bus_if.out_valid, 1'b0);
    check("midreset_out_data", bus_if.out_data, 16'h0000);
    check("midreset_out_zero", bus_if.out_zero, 1'b1);
    @(posedge clk);
    #3 reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("midreset_no_output", n_out - out_before, 0);
    run_directed("post_reset_word", 3'b000, 4'd8, 16'h12AB, 16'hAB12, 1'b0);

    // Random sweep with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus_if.in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          drive_word(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 16'hFFFF)));
        end
        bus_if.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus_if.out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    drain("random_drain");
    repeat (2) @(posedge clk);
    #1;

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
